// File: rtl/bcd_to_bin_converter_if.sv
// Handshake bundle between a BCD producer, the converter and a binary consumer.
interface bcd_to_bin_converter_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    // Producer/consumer side: offers BCD words and accepts binary results.
    modport master (
        output in_valid,
        output bcd_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bin_out,
        input  err
    );

    // Converter side.
    modport slave (
        input  in_valid,
        input  bcd_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bin_out,
        output err
    );
endinterface

// File: rtl/bcd_to_bin_converter.sv
// Packed BCD to unsigned binary, one digit per cycle, most significant digit first.
//
//   state | meaning
//   IDLE  | waiting for a word; in_ready follows ena
//   CONV  | folding one digit per enabled cycle into acc (acc*10 + digit)
//   DONE  | result presented on bin_out/err until out_ready retires it
module bcd_to_bin_converter #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    bcd_to_bin_converter_if.slave     bus
);
    localparam int SR_W  = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [SR_W-1:0]   sreg;
    logic [BIN_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              err_pend;
    logic              out_valid_r;
    logic [BIN_W-1:0]  bin_r;
    logic              err_r;

    logic [3:0]        top_digit;
    logic [BIN_W-1:0]  acc_next;
    logic              bad_digit;

    assign top_digit = sreg[SR_W-1 -: 4];
    // acc*10 without a multiplier; wraps silently, only matters for illegal input.
    assign acc_next  = (acc << 3) + (acc << 1) + BIN_W'(top_digit);

    // Flag any nibble outside 0..9 in the word being offered.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE) && ena;
    assign bus.out_valid = out_valid_r;
    assign bus.bin_out   = bin_r;
    assign bus.err       = err_r;

    // Sequencer and datapath; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sreg        <= '0;
            acc         <= '0;
            cnt         <= '0;
            err_pend    <= 1'b0;
            out_valid_r <= 1'b0;
            bin_r       <= '0;
            err_r       <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg     <= bus.bcd_in;
                        acc      <= '0;
                        cnt      <= '0;
                        err_pend <= bad_digit;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc  <= acc_next;
                    sreg <= sreg << 4;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(DIGITS - 1)) begin
                        bin_r       <= err_pend ? '0 : acc_next;
                        err_r       <= err_pend;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Directed bench for bcd_to_bin_converter with hand-computed results.
module tb_bcd_to_bin_converter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    bcd_to_bin_converter_if #(.DIGITS(3), .BIN_W(10)) bus();

    bcd_to_bin_converter #(.DIGITS(3), .BIN_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 time unit after the accepting edge.
    task automatic send(input logic [11:0] bcd);
        int waited = 0;
        bus.bcd_in   = bcd;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 20) begin
            step();
            waited++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic convert(input logic [11:0] bcd, input int exp_bin, input logic exp_err, input string tag);
        int lat;
        send(bcd);
        wait_out(lat);
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        step();
        check({tag, "_retire"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.bcd_in    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_ov", 32'(bus.out_valid), 32'd0);
        check("rst_bin", 32'(bus.bin_out), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
        step();
        check("rst_ready", 32'(bus.in_ready), 32'd1);

        // Basic conversion and boundaries
        convert(12'h255, 255, 1'b0, "t255");
        convert(12'h000, 0,   1'b0, "t000");
        convert(12'h009, 9,   1'b0, "t009");
        convert(12'h090, 90,  1'b0, "t090");
        convert(12'h999, 999, 1'b0, "t999");

        // Illegal nibble, then a legal word clears err
        convert(12'h1A3, 0,   1'b1, "t1A3");
        convert(12'h123, 123, 1'b0, "t123");

        // Backpressure
        bus.out_ready = 1'b0;
        send(12'h407);
        wait_out(lat);
        check("bp_lat", 32'(lat), 32'd3);
        bus.bcd_in   = 12'h111;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("bp_ov", 32'(bus.out_valid), 32'd1);
            check("bp_bin", 32'(bus.bin_out), 32'd407);
            check("bp_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_retire", 32'(bus.out_valid), 32'd0);
        check("bp_ready_back", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp_accepted", 32'(bus.in_ready), 32'd0);
        wait_out(lat);
        check("bp111_lat", 32'(lat), 32'd3);
        check("bp111_bin", 32'(bus.bin_out), 32'd111);
        step();

        // Enable gating while idle
        ena = 1'b0;
        #1;
        check("ena_idle_ready", 32'(bus.in_ready), 32'd0);
        ena = 1'b1;
        #1;
        check("ena_idle_ready_back", 32'(bus.in_ready), 32'd1);

        // ena dropped mid-conversion
        send(12'h321);
        step();
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ena_ov", 32'(bus.out_valid), 32'd0);
            check("ena_ready", 32'(bus.in_ready), 32'd0);
        end
        ena = 1'b1;
        wait_out(lat);
        check("ena_lat", 32'(lat + 5), 32'd7);
        check("ena_bin", 32'(bus.bin_out), 32'd321);
        step();

        // Asynchronous reset mid-conversion
        send(12'h888);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ov", 32'(bus.out_valid), 32'd0);
        check("arst_bin", 32'(bus.bin_out), 32'd0);
        check("arst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst_ready", 32'(bus.in_ready), 32'd1);
        check("arst_ov_after", 32'(bus.out_valid), 32'd0);
        convert(12'h050, 50, 1'b0, "t050");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
